// File: rtl/uart_cmd_parser.sv
// UART command frame parser: decodes HDR/CMD/payload/TRL frames, updates the
// operand dimension, launches runs and streams loaded operands into FIFO A or B.
module uart_cmd_parser #(
    parameter logic [7:0] HDR   = 8'hFE,
    parameter logic [7:0] TRL   = 8'hEF,
    parameter int         MAX_N = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_interrupt,
    input  logic [7:0] rx_data,
    input  logic       full_A,
    input  logic       full_B,
    output logic       push_A,
    output logic       push_B,
    output logic [7:0] push_data,
    output logic [2:0] N,
    output logic       start,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [7:0] CMD_SET_N  = 8'h01;
    localparam logic [7:0] CMD_START  = 8'h02;
    localparam logic [7:0] CMD_LOAD_A = 8'h03;
    localparam logic [7:0] CMD_LOAD_B = 8'h04;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_PAYLOAD, S_TAIL, S_PUSH} state_t;
    typedef enum logic [1:0] {OP_SET, OP_START, OP_LOAD_A, OP_LOAD_B} op_t;

    state_t     state;
    op_t        op;
    logic [2:0] len;
    logic [2:0] count;
    logic [2:0] idx;
    logic [7:0] buffer [MAX_N];

    logic       tgt_full;
    logic       load_go;
    logic       push_go;
    logic       push_last;
    logic [2:0] push_idx;
    logic       set_ok;

    // The first push is issued on the same edge that accepts TRL, so the
    // push path looks at both the TAIL acceptance and the PUSH state.
    always_comb begin
        tgt_full  = (op == OP_LOAD_B) ? full_B : full_A;
        load_go   = (state == S_TAIL) && rx_interrupt && (rx_data == TRL) &&
                    ((op == OP_LOAD_A) || (op == OP_LOAD_B));
        push_idx  = load_go ? 3'd0 : idx;
        push_go   = (load_go || (state == S_PUSH)) && !tgt_full;
        push_last = ({1'b0, push_idx} + 4'd1) == {1'b0, len};
        set_ok    = (buffer[0] != 8'd0) && (buffer[0] <= 8'(MAX_N));
    end

    always_ff @(posedge clk) begin
        if ((state == S_PAYLOAD) && rx_interrupt)
            buffer[count] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            op        <= OP_SET;
            len       <= 3'd0;
            count     <= 3'd0;
            idx       <= 3'd0;
            N         <= 3'd5;
            push_A    <= 1'b0;
            push_B    <= 1'b0;
            push_data <= 8'd0;
            start     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_A    <= 1'b0;
            push_B    <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_interrupt && (rx_data == HDR))
                        state <= S_CMD;
                end
                S_CMD: begin
                    if (rx_interrupt) begin
                        count <= 3'd0;
                        if (rx_data == CMD_SET_N) begin
                            op    <= OP_SET;
                            len   <= 3'd1;
                            state <= S_PAYLOAD;
                        end else if (rx_data == CMD_START) begin
                            op    <= OP_START;
                            len   <= 3'd0;
                            state <= S_TAIL;
                        end else if (rx_data == CMD_LOAD_A) begin
                            op    <= OP_LOAD_A;
                            len   <= N;
                            state <= S_PAYLOAD;
                        end else if (rx_data == CMD_LOAD_B) begin
                            op    <= OP_LOAD_B;
                            len   <= N;
                            state <= S_PAYLOAD;
                        end else if (rx_data != HDR) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_interrupt) begin
                        count <= count + 3'd1;
                        if (({1'b0, count} + 4'd1) == {1'b0, len})
                            state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (rx_interrupt) begin
                        if (rx_data != TRL) begin
                            frame_err <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            case (op)
                                OP_SET: begin
                                    if (set_ok)
                                        N <= buffer[0][2:0];
                                    else
                                        frame_err <= 1'b1;
                                    state <= S_IDLE;
                                end
                                OP_START: begin
                                    start <= 1'b1;
                                    state <= S_IDLE;
                                end
                                default: begin
                                    idx   <= 3'd0;
                                    busy  <= 1'b1;
                                    state <= (push_go && push_last) ? S_IDLE : S_PUSH;
                                end
                            endcase
                        end
                    end
                end
                S_PUSH: begin
                    // Bytes arriving while draining are dropped and flagged.
                    busy      <= 1'b1;
                    frame_err <= rx_interrupt;
                    if (push_go && push_last)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (push_go) begin
                push_A    <= (op == OP_LOAD_A);
                push_B    <= (op == OP_LOAD_B);
                push_data <= buffer[push_idx];
                idx       <= push_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame table plus hand-timed sequences; pushes are
// checked against a scoreboard queue filled as frames are sent.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_interrupt = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       full_A = 1'b0;
    logic       full_B = 1'b0;
    logic       push_A, push_B, start, busy, frame_err;
    logic [7:0] push_data;
    logic [2:0] N;

    uart_cmd_parser dut (
        .clk(clk), .rst(rst), .rx_interrupt(rx_interrupt), .rx_data(rx_data),
        .full_A(full_A), .full_B(full_B), .push_A(push_A), .push_B(push_B),
        .push_data(push_data), .N(N), .start(start), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_b;
        logic [7:0] data;
    } push_t;

    typedef struct {
        string       name;
        logic [95:0] f;
        int          nb;
        int          pay_off;
        int          n_pay;
        logic        is_b;
        int          exp_start;
        int          exp_err;
        int          exp_n;
    } vec_t;

    push_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    n_push = 0;
    int    n_start = 0;
    int    n_err = 0;
    logic  prev_start = 1'b0;
    logic  prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops and pulse-width checks.
    always @(negedge clk) begin
        if (push_A || push_B) begin
            n_push++;
            check("push_exclusive", {31'd0, push_A && push_B}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL push_unexpected: got data %0h with no pending entry", push_data);
            end else begin
                push_t e;
                e = exp_q.pop_front();
                check("push_data", {24'd0, push_data}, {24'd0, e.data});
                check("push_target", {31'd0, push_B}, {31'd0, e.is_b});
            end
        end
        if (start) begin
            n_start++;
            check("start_width", {31'd0, prev_start}, 32'd0);
        end
        if (frame_err) begin
            n_err++;
            check("err_width", {31'd0, prev_err}, 32'd0);
        end
        prev_start = start;
        prev_err   = frame_err;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_interrupt = 1'b1;
        rx_data      = b;
        @(posedge clk); #1;
        rx_interrupt = 1'b0;
    endtask

    task automatic send_frame(input logic [95:0] f, input int nb);
        for (int i = 0; i < nb; i++)
            send_byte(f[8*(nb-1-i) +: 8]);
    endtask

    task automatic expect_push(input logic is_b, input logic [7:0] d);
        push_t e;
        e.is_b = is_b;
        e.data = d;
        exp_q.push_back(e);
    endtask

    vec_t vecs[15];

    initial begin
        int s0, e0, p0;

        vecs[0]  = '{"start_def",  96'hFE02EF,               3,  0, 0, 1'b0, 1, 0, 5};
        vecs[1]  = '{"setn3",      96'hFE0103EF,             4,  0, 0, 1'b0, 0, 0, 3};
        vecs[2]  = '{"loadA3",     96'hFE030A0B0CEF,         6,  2, 3, 1'b0, 0, 0, 3};
        vecs[3]  = '{"setn0",      96'hFE0100EF,             4,  0, 0, 1'b0, 0, 1, 3};
        vecs[4]  = '{"setn8",      96'hFE0108EF,             4,  0, 0, 1'b0, 0, 1, 3};
        vecs[5]  = '{"bad_trl",    96'hFE0311223355,         6,  0, 0, 1'b0, 0, 1, 3};
        vecs[6]  = '{"resync",     96'hFEFE02EF,             4,  0, 0, 1'b0, 1, 0, 3};
        vecs[7]  = '{"bad_cmd",    96'hFE09,                 2,  0, 0, 1'b0, 0, 1, 3};
        vecs[8]  = '{"loadB_hdr",  96'h33FE04FEEF01EF,       7,  3, 3, 1'b1, 0, 0, 3};
        vecs[9]  = '{"setn7",      96'hFE0107EF,             4,  0, 0, 1'b0, 0, 0, 7};
        vecs[10] = '{"loadB7",     96'hFE0401020304050607EF, 10, 2, 7, 1'b1, 0, 0, 7};
        vecs[11] = '{"setn1",      96'hFE0101EF,             4,  0, 0, 1'b0, 0, 0, 1};
        vecs[12] = '{"loadA1",     96'hFE035AEF,             4,  2, 1, 1'b0, 0, 0, 1};
        vecs[13] = '{"setn5",      96'hFE0105EF,             4,  0, 0, 1'b0, 0, 0, 5};
        vecs[14] = '{"trl_as_cmd", 96'hFEEF,                 2,  0, 0, 1'b0, 0, 1, 5};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_push_A", {31'd0, push_A}, 32'd0);
        check("rst_push_B", {31'd0, push_B}, 32'd0);
        check("rst_push_data", {24'd0, push_data}, 32'd0);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check("rst_N", {29'd0, N}, 32'd5);
        rst = 1'b1;

        // START: pulse right after the TRL edge, one cycle wide
        send_frame(96'hFE02EF, 3);
        check("v1_start_t1", {31'd0, start}, 32'd1);
        @(posedge clk); #1;
        check("v1_start_t2", {31'd0, start}, 32'd0);
        check("v1_N", {29'd0, N}, 32'd5);

        for (int v = 0; v < 15; v++) begin
            s0 = n_start; e0 = n_err; p0 = n_push;
            for (int j = 0; j < vecs[v].n_pay; j++)
                expect_push(vecs[v].is_b, vecs[v].f[8*(vecs[v].nb-1-(vecs[v].pay_off+j)) +: 8]);
            send_frame(vecs[v].f, vecs[v].nb);
            repeat (10) @(posedge clk);
            #1;
            check({vecs[v].name, "_start"}, n_start - s0, vecs[v].exp_start);
            check({vecs[v].name, "_err"}, n_err - e0, vecs[v].exp_err);
            check({vecs[v].name, "_pushes"}, n_push - p0, vecs[v].n_pay);
            check({vecs[v].name, "_N"}, {29'd0, N}, vecs[v].exp_n);
            check({vecs[v].name, "_q_empty"}, exp_q.size(), 0);
            exp_q.delete();
        end

        // LOAD_A: three back-to-back pushes starting on the TRL edge
        send_frame(96'hFE0103EF, 4);
        expect_push(1'b0, 8'h0A); expect_push(1'b0, 8'h0B); expect_push(1'b0, 8'h0C);
        send_frame(96'hFE030A0B0CEF, 6);
        for (int k = 0; k < 3; k++) begin
            check("v2_push_A", {31'd0, push_A}, 32'd1);
            check("v2_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        check("v2_push_A_end", {31'd0, push_A}, 32'd0);
        check("v2_busy_end", {31'd0, busy}, 32'd0);

        // LOAD_B with full_B stalling cycles 2-4
        p0 = n_push;
        expect_push(1'b1, 8'h21); expect_push(1'b1, 8'h22); expect_push(1'b1, 8'h23);
        send_frame(96'hFE04212223EF, 6);
        check("v3_push1", {31'd0, push_B}, 32'd1);
        full_B = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("v3_stall_push", {31'd0, push_B}, 32'd0);
            check("v3_stall_busy", {31'd0, busy}, 32'd1);
        end
        full_B = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("v3_resume", {31'd0, push_B}, 32'd1);
        end
        @(posedge clk); #1;
        check("v3_busy_end", {31'd0, busy}, 32'd0);
        check("v3_total", n_push - p0, 3);
        check("v3_q_empty", exp_q.size(), 0);

        // Byte received while PUSH is stalled: flagged and dropped
        p0 = n_push; e0 = n_err;
        full_A = 1'b1;
        expect_push(1'b0, 8'h31); expect_push(1'b0, 8'h32); expect_push(1'b0, 8'h33);
        send_frame(96'hFE03313233EF, 6);
        check("pe_busy", {31'd0, busy}, 32'd1);
        check("pe_no_push", {31'd0, push_A}, 32'd0);
        send_byte(8'hFE);
        check("pe_err", {31'd0, frame_err}, 32'd1);
        full_A = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pe_total", n_push - p0, 3);
        check("pe_err_cnt", n_err - e0, 1);
        check("pe_q_empty", exp_q.size(), 0);

        // Reset in the middle of a 5-byte push
        send_frame(96'hFE0105EF, 4);
        p0 = n_push;
        for (int j = 0; j < 5; j++) expect_push(1'b0, 8'h41 + 8'(j));
        send_frame(96'hFE034142434445EF, 8);
        @(posedge clk); #1;
        check("v6_push2", {31'd0, push_A}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("v6_push_A", {31'd0, push_A}, 32'd0);
        check("v6_push_data", {24'd0, push_data}, 32'd0);
        check("v6_busy", {31'd0, busy}, 32'd0);
        check("v6_start", {31'd0, start}, 32'd0);
        check("v6_err", {31'd0, frame_err}, 32'd0);
        check("v6_N", {29'd0, N}, 32'd5);
        rst = 1'b1;
        exp_q.delete();
        repeat (8) @(posedge clk);
        #1;
        check("v6_total", n_push - p0, 2);
        s0 = n_start;
        send_frame(96'hFE02EF, 3);
        repeat (3) @(posedge clk);
        #1;
        check("v6_start_after", n_start - s0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
